// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: digit count and
// active-low segment patterns ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [IDX_W-1:0]      digit_idx_t;
    typedef logic [NUM_DIGITS-1:0] an_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam an_t AN_OFF = '1;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Non-decimal nibbles show a dash so corrupt counts are visible.
module bcd_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Lookup of the segment pattern for one nibble
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver. A prescaler paces the
// digit index; the BCD word is snapshotted once per frame so a digit
// never changes part-way through a scan. Outputs are registered.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        enable,
    input  logic        lzb,
    input  logic        colon,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int                CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  PRESC_MAX = CNT_W'(SCAN_DIV - 1);
    localparam digit_idx_t        IDX_LAST  = digit_idx_t'(NUM_DIGITS - 1);
    localparam digit_idx_t        IDX_COLON = digit_idx_t'(2);

    logic [CNT_W-1:0] r_presc;
    digit_idx_t       r_idx;
    logic [15:0]      r_shadow;
    an_t              r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic             w_tick;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg_dec;
    logic             w_lz_blank;
    an_t              w_an_sel;
    logic [6:0]       w_seg_next;
    logic             w_dp_next;

    assign w_tick = (r_presc == PRESC_MAX);

    // Prescaler, digit index and once-per-frame value snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_shadow <= 16'h0000;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= r_idx + 1'b1;
                if (r_idx == IDX_LAST) begin
                    r_shadow <= value;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .i_bcd (w_nibble),
        .o_seg (w_seg_dec)
    );

    // Leading-zero blanking: a digit blanks only if it and every digit to its left are zero
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd3:    w_lz_blank = (r_shadow[15:12] == 4'd0);
            2'd2:    w_lz_blank = (r_shadow[15:8]  == 8'd0);
            2'd1:    w_lz_blank = (r_shadow[15:4]  == 12'd0);
            default: w_lz_blank = 1'b0;
        endcase
        w_lz_blank = w_lz_blank & lzb;
    end

    // Next-cycle output values from the current index and snapshot
    always_comb begin
        w_an_sel   = ~(an_t'(1) << r_idx);
        w_seg_next = (!enable || w_lz_blank) ? SEG_BLANK : w_seg_dec;
        w_dp_next  = ~(enable && colon && (r_idx == IDX_COLON));
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= enable ? w_an_sel : AN_OFF;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with SCAN_DIV=4. Edge numbers in the
// comments count rising edges after reset release, starting at 0; after
// edge e the outputs show digit (e/4)%4 and a snapshot is taken at edges
// where e%16 == 15.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        enable;
    logic        lzb;
    logic        colon;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_tests = 0;
    int n_fail  = 0;

    seven_seg_scan #(.SCAN_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .value  (value),
        .enable (enable),
        .lzb    (lzb),
        .colon  (colon),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_an,
                       input logic [6:0] e_seg, input logic e_dp);
        n_tests++;
        assert ({an, seg, dp} === {e_an, e_seg, e_dp})
        else begin
            n_fail++;
            $error("FAIL %s: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                   tag, an, seg, dp, e_an, e_seg, e_dp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        value  = 16'h5959;
        enable = 1'b1;
        lzb    = 1'b0;
        colon  = 1'b0;
        step(3);
        chk("reset_hold", 4'b1111, 7'b1111111, 1'b1);
        reset = 1'b0;

        step(1);   // edge 0
        chk("first_after_reset", 4'b1110, 7'b1000000, 1'b1);
        step(3);   // edge 3
        chk("d0_slot_end", 4'b1110, 7'b1000000, 1'b1);
        step(1);   // edge 4
        chk("d1_first_frame", 4'b1101, 7'b1000000, 1'b1);
        step(4);   // edge 8
        chk("d2_first_frame", 4'b1011, 7'b1000000, 1'b1);
        step(4);   // edge 12
        chk("d3_first_frame", 4'b0111, 7'b1000000, 1'b1);
        step(3);   // edge 15, snapshot of 5959
        chk("d3_slot_end", 4'b0111, 7'b1000000, 1'b1);
        step(1);   // edge 16
        chk("5959_d0", 4'b1110, 7'b0010000, 1'b1);
        step(4);   // edge 20
        chk("5959_d1", 4'b1101, 7'b0010010, 1'b1);

        value = 16'h1234;   // snapshot at edge 31
        step(16);  // edge 36
        chk("1234_d1", 4'b1101, 7'b0110000, 1'b1);
        value = 16'h5678;   // mid-frame change
        step(4);   // edge 40
        chk("midframe_d2_old", 4'b1011, 7'b0100100, 1'b1);
        step(4);   // edge 44
        chk("midframe_d3_old", 4'b0111, 7'b1111001, 1'b1);
        step(4);   // edge 48
        chk("5678_d0", 4'b1110, 7'b0000000, 1'b1);
        step(4);   // edge 52
        chk("5678_d1", 4'b1101, 7'b1111000, 1'b1);
        step(4);   // edge 56
        chk("5678_d2", 4'b1011, 7'b0000010, 1'b1);
        step(4);   // edge 60
        chk("5678_d3", 4'b0111, 7'b0010010, 1'b1);

        value = 16'h9A09;   // snapshot at edge 63
        step(4);   // edge 64
        chk("9A09_d0", 4'b1110, 7'b0010000, 1'b1);
        step(4);   // edge 68
        chk("9A09_d1", 4'b1101, 7'b1000000, 1'b1);
        step(4);   // edge 72
        chk("9A09_d2_dash", 4'b1011, 7'b0111111, 1'b1);
        step(4);   // edge 76
        chk("9A09_d3", 4'b0111, 7'b0010000, 1'b1);

        value = 16'h0007;   // snapshot at edge 79
        lzb   = 1'b1;
        step(4);   // edge 80
        chk("lzb_0007_d0", 4'b1110, 7'b1111000, 1'b1);
        step(4);   // edge 84
        chk("lzb_0007_d1", 4'b1101, 7'b1111111, 1'b1);
        step(4);   // edge 88
        chk("lzb_0007_d2", 4'b1011, 7'b1111111, 1'b1);
        step(4);   // edge 92
        chk("lzb_0007_d3", 4'b0111, 7'b1111111, 1'b1);
        value = 16'h0000;   // snapshot at edge 95
        step(4);   // edge 96
        chk("lzb_0000_d0", 4'b1110, 7'b1000000, 1'b1);
        step(4);   // edge 100
        chk("lzb_0000_d1", 4'b1101, 7'b1111111, 1'b1);

        colon = 1'b1;
        step(3);   // edge 103
        chk("colon_d1", 4'b1101, 7'b1111111, 1'b1);
        step(1);   // edge 104
        chk("colon_d2", 4'b1011, 7'b1111111, 1'b0);
        step(4);   // edge 108
        chk("colon_d3", 4'b0111, 7'b1111111, 1'b1);

        enable = 1'b0;
        step(1);   // edge 109
        chk("disabled_d3_slot", 4'b1111, 7'b1111111, 1'b1);
        step(3);   // edge 112
        chk("disabled_d0_slot", 4'b1111, 7'b1111111, 1'b1);
        step(8);   // edge 120
        chk("disabled_d2_slot", 4'b1111, 7'b1111111, 1'b1);
        enable = 1'b1;
        step(1);   // edge 121, index kept running while blanked
        chk("reenable_d2", 4'b1011, 7'b1111111, 1'b0);

        value = 16'h4321;
        reset = 1'b1;
        step(1);
        chk("midframe_reset", 4'b1111, 7'b1111111, 1'b1);
        reset = 1'b0;
        step(1);   // new edge 0, snapshot cleared
        chk("after_reset_d0", 4'b1110, 7'b1000000, 1'b1);
        step(3);   // edge 3
        chk("after_reset_hold", 4'b1110, 7'b1000000, 1'b1);
        step(1);   // edge 4
        chk("after_reset_advance", 4'b1101, 7'b1111111, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
